branch_predictor: RTL and testbench

- Dynamic conditional-branch predictor directly upstream of the branch resolver unit (BRU).
- Fetch queries it with a branch PC and immediate. It returns a taken/not-taken prediction and the speculative target, and keeps each in-flight prediction in order in a small FIFO.
- The FIFO head drives the BRU prediction input. BRU resolution feedback (enable, taken, flush) trains a table of 2-bit saturating counters and retires or flushes FIFO entries.

---
 rtl/branch_predictor.sv | 123 ++++++++++++
 tb/tb_branch_predictor.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Dynamic conditional-branch predictor: 2-bit saturating counter table indexed by PC,
// plus an in-order FIFO of in-flight predictions whose head feeds the branch resolver.

module bp_counter (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic taken
);
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} state_t;
  state_t state;

  always_ff @(posedge clk) begin
    if (rst) state <= WNT;
    else if (inc) begin
      case (state)
        SNT:     state <= WNT;
        WNT:     state <= WT;
        default: state <= ST;
      endcase
    end else if (dec) begin
      case (state)
        ST:      state <= WT;
        WT:      state <= WNT;
        default: state <= SNT;
      endcase
    end
  end

  assign taken = state[1];
endmodule

module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  lookup_valid_in,
  input  logic [DATA_WIDTH-1:0] lookup_pc_in,
  input  logic [DATA_WIDTH-1:0] lookup_imm_in,
  output logic                  lookup_ready_out,
  output logic                  pred_taken_out,
  output logic [DATA_WIDTH-1:0] pred_target_out,
  output logic                  pred_valid_out,
  output logic                  pred_out,
  input  logic                  update_enable_in,
  input  logic                  update_taken_in,
  input  logic                  flush_in,
  output logic                  err_out
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [INDEX_BITS-1:0] idx;
    logic                  pred;
  } entry_t;

  entry_t                fifo_q [FIFO_DEPTH];
  entry_t                head;
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [PTR_W:0]        count;
  logic [ENTRIES-1:0]    ctr_taken, upd_hit;
  logic [INDEX_BITS-1:0] lk_idx;
  logic                  push, pop, empty;

  assign lk_idx           = lookup_pc_in[INDEX_BITS+1:2];
  assign empty            = (count == '0);
  assign lookup_ready_out = (count != (PTR_W+1)'(FIFO_DEPTH));
  assign pred_taken_out   = ctr_taken[lk_idx];
  assign pred_target_out  = lookup_pc_in + (pred_taken_out ? lookup_imm_in : DATA_WIDTH'(4));

  // A lookup in a flush cycle is on the wrong path and must not enter the FIFO.
  assign push = lookup_valid_in & lookup_ready_out & ~flush_in;
  assign pop  = update_enable_in & ~empty;

  assign head           = fifo_q[rd_ptr];
  assign pred_valid_out = ~empty;
  assign pred_out       = ~empty & head.pred;
  assign upd_hit        = pop ? (ENTRIES'(1) << head.idx) : '0;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    bp_counter u_ctr (
      .clk   (clk_in),
      .rst   (rst_in),
      .inc   (upd_hit[i] & update_taken_in),
      .dec   (upd_hit[i] & ~update_taken_in),
      .taken (ctr_taken[i])
    );
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      err_out <= 1'b0;
    end else begin
      if (update_enable_in && empty) err_out <= 1'b1;
      if (flush_in) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + (PTR_W+1)'(1);
          2'b01:   count <= count - (PTR_W+1)'(1);
          default: ;
        endcase
      end
    end
  end

  // Storage needs no reset: entries are only observed while counted as valid.
  always_ff @(posedge clk_in) begin
    if (push) fifo_q[wr_ptr] <= '{idx: lk_idx, pred: pred_taken_out};
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, training, FIFO order/full, flush, aliasing, underflow.
module tb_branch_predictor;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        lookup_valid_in = 1'b0;
  logic [31:0] lookup_pc_in = '0;
  logic [31:0] lookup_imm_in = '0;
  logic        lookup_ready_out, pred_taken_out, pred_valid_out, pred_out, err_out;
  logic [31:0] pred_target_out;
  logic        update_enable_in = 1'b0;
  logic        update_taken_in = 1'b0;
  logic        flush_in = 1'b0;
  int total = 0;
  int bad = 0;

  branch_predictor #(.DATA_WIDTH(32), .INDEX_BITS(6), .FIFO_DEPTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .lookup_valid_in(lookup_valid_in), .lookup_pc_in(lookup_pc_in), .lookup_imm_in(lookup_imm_in),
    .lookup_ready_out(lookup_ready_out), .pred_taken_out(pred_taken_out),
    .pred_target_out(pred_target_out), .pred_valid_out(pred_valid_out), .pred_out(pred_out),
    .update_enable_in(update_enable_in), .update_taken_in(update_taken_in),
    .flush_in(flush_in), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in); #1;
  endtask

  task automatic idle;
    lookup_valid_in = 0; update_enable_in = 0; update_taken_in = 0; flush_in = 0;
  endtask

  task automatic do_reset;
    idle(); rst_in = 1; tick(); rst_in = 0;
  endtask

  task automatic push_pc(input logic [31:0] pc);
    lookup_valid_in = 1; lookup_pc_in = pc; lookup_imm_in = 32'h20; tick(); lookup_valid_in = 0;
  endtask

  task automatic pop_upd(input logic tk);
    update_enable_in = 1; update_taken_in = tk; tick(); update_enable_in = 0;
  endtask

  task automatic test_reset;
    idle(); rst_in = 1; tick(); tick(); rst_in = 0;
    lookup_pc_in = 32'h100; lookup_imm_in = 32'h20; #1;
    total++; if (pred_taken_out !== 1'b0) begin bad++; $display("FAIL reset_taken got=%0h want=0", pred_taken_out); end
    total++; if (pred_target_out !== 32'h104) begin bad++; $display("FAIL reset_target got=%0h want=104", pred_target_out); end
    total++; if (lookup_ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h want=1", lookup_ready_out); end
    total++; if (pred_valid_out !== 1'b0) begin bad++; $display("FAIL reset_pvalid got=%0h want=0", pred_valid_out); end
    total++; if (pred_out !== 1'b0) begin bad++; $display("FAIL reset_pred got=%0h want=0", pred_out); end
    total++; if (err_out !== 1'b0) begin bad++; $display("FAIL reset_err got=%0h want=0", err_out); end
  endtask

  task automatic test_training;
    logic up [3] = '{1'b0, 1'b1, 1'b1};
    logic dn [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      lookup_valid_in = 1; lookup_pc_in = 32'h100; lookup_imm_in = 32'h20; #1;
      total++; if (pred_taken_out !== up[k]) begin bad++; $display("FAIL train_up%0d got=%0h want=%0h", k, pred_taken_out, up[k]); end
      tick(); lookup_valid_in = 0; #1;
      total++; if (pred_out !== up[k] || pred_valid_out !== 1'b1) begin bad++; $display("FAIL train_head%0d got=%0h/%0h want=%0h/1", k, pred_out, pred_valid_out, up[k]); end
      pop_upd(1'b1);
    end
    lookup_pc_in = 32'h100; lookup_imm_in = 32'h20; #1;
    total++; if (pred_taken_out !== 1'b1 || pred_target_out !== 32'h120) begin bad++; $display("FAIL train_sat got=%0h/%0h want=1/120", pred_taken_out, pred_target_out); end
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (pred_taken_out !== dn[k]) begin bad++; $display("FAIL train_dn%0d got=%0h want=%0h", k, pred_taken_out, dn[k]); end
      push_pc(32'h100); pop_upd(1'b0);
    end
    #1;
    total++; if (pred_taken_out !== 1'b0 || pred_target_out !== 32'h104) begin bad++; $display("FAIL train_floor got=%0h/%0h want=0/104", pred_taken_out, pred_target_out); end
  endtask

  task automatic test_full;
    do_reset(); push_pc(32'h104); pop_upd(1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (lookup_ready_out !== 1'b1) begin bad++; $display("FAIL full_ready%0d got=%0h want=1", k, lookup_ready_out); end
      push_pc(k[0] ? 32'h104 : 32'h100);
    end
    #1;
    total++; if (lookup_ready_out !== 1'b0) begin bad++; $display("FAIL full_notready got=%0h want=0", lookup_ready_out); end
    lookup_valid_in = 1; lookup_pc_in = 32'h100; tick();
    total++; if (lookup_ready_out !== 1'b0 || pred_valid_out !== 1'b1) begin bad++; $display("FAIL full_fifth got=%0h/%0h want=0/1", lookup_ready_out, pred_valid_out); end
    for (int k = 0; k < 4; k++) begin
      lookup_valid_in = (k == 0); update_enable_in = 1; update_taken_in = 0; #1;
      total++; if (pred_out !== k[0] || pred_valid_out !== 1'b1) begin bad++; $display("FAIL full_order%0d got=%0h/%0h want=%0h/1", k, pred_out, pred_valid_out, k[0]); end
      tick();
    end
    idle(); #1;
    total++; if (pred_valid_out !== 1'b0 || lookup_ready_out !== 1'b1) begin bad++; $display("FAIL full_drain got=%0h/%0h want=0/1", pred_valid_out, lookup_ready_out); end
  endtask

  task automatic test_flush;
    do_reset();
    for (int k = 0; k < 3; k++) push_pc(32'h100);
    lookup_valid_in = 1; lookup_pc_in = 32'h100; update_enable_in = 1; update_taken_in = 1; flush_in = 1; #1;
    total++; if (pred_taken_out !== 1'b0 || pred_valid_out !== 1'b1) begin bad++; $display("FAIL flush_pre got=%0h/%0h want=0/1", pred_taken_out, pred_valid_out); end
    tick(); idle(); #1;
    total++; if (pred_valid_out !== 1'b0 || lookup_ready_out !== 1'b1) begin bad++; $display("FAIL flush_empty got=%0h/%0h want=0/1", pred_valid_out, lookup_ready_out); end
    total++; if (pred_taken_out !== 1'b1) begin bad++; $display("FAIL flush_ctr got=%0h want=1", pred_taken_out); end
    push_pc(32'h104);
    flush_in = 1; tick(); idle(); lookup_pc_in = 32'h100; #1;
    total++; if (pred_valid_out !== 1'b0 || pred_taken_out !== 1'b1 || err_out !== 1'b0) begin bad++; $display("FAIL flush_only got=%0h/%0h/%0h want=0/1/0", pred_valid_out, pred_taken_out, err_out); end
    push_pc(32'h100); #1;
    total++; if (pred_out !== 1'b1 || pred_valid_out !== 1'b1) begin bad++; $display("FAIL flush_restart got=%0h/%0h want=1/1", pred_out, pred_valid_out); end
    pop_upd(1'b1);
  endtask

  task automatic test_alias;
    do_reset(); push_pc(32'h100); pop_upd(1'b1); push_pc(32'h100);
    lookup_pc_in = 32'h200; lookup_imm_in = 32'h40; update_enable_in = 1; update_taken_in = 0; #1;
    total++; if (pred_taken_out !== 1'b1 || pred_target_out !== 32'h240) begin bad++; $display("FAIL alias_same got=%0h/%0h want=1/240", pred_taken_out, pred_target_out); end
    tick(); idle(); #1;
    total++; if (pred_taken_out !== 1'b0 || pred_target_out !== 32'h204) begin bad++; $display("FAIL alias_next got=%0h/%0h want=0/204", pred_taken_out, pred_target_out); end
  endtask

  task automatic test_back_to_back;
    do_reset(); push_pc(32'h104); pop_upd(1'b1);
    lookup_valid_in = 1; lookup_pc_in = 32'h100; #1;
    total++; if (pred_valid_out !== 1'b0 || pred_out !== 1'b0) begin bad++; $display("FAIL b2b_nobypass got=%0h/%0h want=0/0", pred_valid_out, pred_out); end
    tick();
    lookup_pc_in = 32'h104; update_enable_in = 1; update_taken_in = 1; #1;
    total++; if (pred_out !== 1'b0 || pred_taken_out !== 1'b1) begin bad++; $display("FAIL b2b_head got=%0h/%0h want=0/1", pred_out, pred_taken_out); end
    tick(); idle(); lookup_pc_in = 32'h100; #1;
    total++; if (pred_valid_out !== 1'b1 || pred_out !== 1'b1 || lookup_ready_out !== 1'b1) begin bad++; $display("FAIL b2b_swap got=%0h/%0h/%0h want=1/1/1", pred_valid_out, pred_out, lookup_ready_out); end
    total++; if (pred_taken_out !== 1'b1) begin bad++; $display("FAIL b2b_ctr got=%0h want=1", pred_taken_out); end
    pop_upd(1'b0); #1;
    total++; if (pred_valid_out !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0h want=0", pred_valid_out); end
    lookup_pc_in = 32'hFFFF_FFFC; lookup_imm_in = 32'h0; #1;
    total++; if (pred_target_out !== 32'h0) begin bad++; $display("FAIL b2b_wrap got=%0h want=0", pred_target_out); end
  endtask

  task automatic test_underflow;
    do_reset(); pop_upd(1'b1); #1;
    total++; if (err_out !== 1'b1 || pred_valid_out !== 1'b0) begin bad++; $display("FAIL uf_set got=%0h/%0h want=1/0", err_out, pred_valid_out); end
    tick();
    total++; if (err_out !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%0h want=1", err_out); end
    lookup_pc_in = 32'h100; #1;
    total++; if (pred_taken_out !== 1'b0) begin bad++; $display("FAIL uf_tbl0 got=%0h want=0", pred_taken_out); end
    lookup_pc_in = 32'h104; #1;
    total++; if (pred_taken_out !== 1'b0) begin bad++; $display("FAIL uf_tbl1 got=%0h want=0", pred_taken_out); end
    do_reset(); #1;
    total++; if (err_out !== 1'b0) begin bad++; $display("FAIL uf_clear got=%0h want=0", err_out); end
  endtask

  initial begin
    test_reset();
    test_training();
    test_full();
    test_flush();
    test_alias();
    test_back_to_back();
    test_underflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
